// File: rtl/usb_event_annunciator_pkg.sv
// Shared types and constants for the USB event annunciator and its record FIFO.
package usb_event_annunciator_pkg;

   localparam int EP_W  = 4;
   localparam int REC_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IN   = 2'd1,
      ST_OUT  = 2'd2,
      ST_SKIP = 2'd3
   } ann_state_t;

   function automatic logic ep_match(input logic [EP_W-1:0] ep, input int num);
      return ep == EP_W'(num);
   endfunction

endpackage

// File: rtl/usb_annunciator_fifo.sv
// Record ring with separate read and commit pointers so an un-ACKed IN packet can be replayed.
module usb_annunciator_fifo
   import usb_event_annunciator_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    push,
   input  logic [REC_W-1:0]        wdata,
   input  logic                    pop,
   input  logic                    commit,
   input  logic                    rewind,
   output logic [REC_W-1:0]        rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic [AW:0]        cmt_ptr;
   logic [REC_W-1:0]   mem [DEPTH];

   // The caller only pushes when not full; full counts uncommitted bytes too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cmt_ptr <= '0;
      end else if (clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cmt_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (rewind) rd_ptr <= cmt_ptr;
         else if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (commit) cmt_ptr <= rd_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign level = wr_ptr - cmt_ptr;
   assign full  = (level == (AW + 1)'(DEPTH));
   assign empty = (rd_ptr == wr_ptr);

endmodule

// File: rtl/usb_event_annunciator.sv
// Multi-channel event annunciator: queues {channel, count} records and serves them on one IN endpoint,
// with the channel enable mask written by OUT transfers to the same endpoint.
module usb_event_annunciator
   import usb_event_annunciator_pkg::*;
#(
   parameter int NCH       = 4,
   parameter int DEPTH     = 32,
   parameter int MAXPKT    = 8,
   parameter int EP        = 1,
   parameter int BOTH_EDGE = 1
) (
   input  logic                    clk48,
   input  logic                    rst,
   input  logic [NCH-1:0]          inc,
   input  logic                    usb_rst,
   input  logic                    transaction_active,
   input  logic [EP_W-1:0]         endpoint,
   input  logic                    direction_in,
   input  logic                    setup,
   input  logic                    data_strobe,
   input  logic                    success,
   input  logic [7:0]              din,
   input  logic                    din_v,
   output logic [7:0]              dout,
   output logic                    dout_v,
   output logic [NCH-1:0]          lost,
   output logic [$clog2(DEPTH):0]  level,
   output ann_state_t              fsm_state
);

   localparam int CHW = $clog2(NCH);
   localparam int CW  = 8 - CHW;
   localparam int SW  = $clog2(MAXPKT + 1);

   logic [NCH-1:0]   sync1, sync2, sync3, edg, evt;
   logic [NCH-1:0]   pend, take, mask, new_mask;
   logic [CW-1:0]    cnt [NCH];
   logic [CHW-1:0]   sel;
   logic             sel_v, push, full, empty;
   logic [REC_W-1:0] rec, fifo_rdata;
   ann_state_t       state_q, state_d;
   logic             ok_q, pop, commit, rewind, dout_v_c, end_txn;
   logic [SW-1:0]    sent_q;
   logic             unused_din;

   assign unused_din = ^din;

   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= inc;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign edg = (BOTH_EDGE != 0) ? (sync2 ^ sync3) : (sync2 & ~sync3);
   assign evt = edg & mask;

   always_comb begin
      sel   = '0;
      sel_v = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (pend[i]) begin
            sel   = CHW'(i);
            sel_v = 1'b1;
         end
      end
   end

   assign push = sel_v && !full;
   assign take = push ? (NCH'(1) << sel) : '0;
   assign rec  = {sel, cnt[sel]};

   // A new event on a channel being pushed this cycle is not a loss: the old record leaves now.
   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
         pend <= '0;
         lost <= '0;
         for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      end else if (usb_rst) begin
         pend <= '0;
         lost <= '0;
         for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (evt[i]) begin
               cnt[i]  <= cnt[i] + CW'(1);
               pend[i] <= 1'b1;
               if (pend[i] && !take[i]) lost[i] <= 1'b1;
            end else if (take[i]) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   usb_annunciator_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk48),
      .rst    (rst),
      .clr    (usb_rst),
      .push   (push),
      .wdata  (rec),
      .pop    (pop),
      .commit (commit),
      .rewind (rewind),
      .rdata  (fifo_rdata),
      .full   (full),
      .empty  (empty),
      .level  (level)
   );

   assign end_txn = (state_q != ST_IDLE) && !transaction_active;

   always_comb begin
      state_d  = state_q;
      dout_v_c = 1'b0;
      pop      = 1'b0;
      commit   = 1'b0;
      rewind   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (transaction_active) begin
               if (ep_match(endpoint, EP) && !setup) state_d = direction_in ? ST_IN : ST_OUT;
               else state_d = ST_SKIP;
            end
         end
         ST_IN: begin
            if (!transaction_active) begin
               state_d = ST_IDLE;
               commit  = ok_q;
               rewind  = !ok_q;
            end else begin
               dout_v_c = !empty && (sent_q < SW'(MAXPKT));
               pop      = data_strobe && dout_v_c;
            end
         end
         default: begin
            if (!transaction_active) state_d = ST_IDLE;
         end
      endcase
   end

   // new_mask tracks mask while idle so an ACKed OUT without data leaves the mask as it was.
   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ok_q     <= 1'b0;
         sent_q   <= '0;
         mask     <= '1;
         new_mask <= '1;
      end else if (usb_rst) begin
         state_q  <= ST_IDLE;
         ok_q     <= 1'b0;
         sent_q   <= '0;
         mask     <= '1;
         new_mask <= '1;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE) new_mask <= mask;
         else if (state_q == ST_OUT && data_strobe && din_v) new_mask <= din[NCH-1:0];
         if (end_txn) begin
            ok_q   <= 1'b0;
            sent_q <= '0;
            if (state_q == ST_OUT && ok_q) mask <= new_mask;
         end else begin
            if (success && state_q != ST_IDLE) ok_q <= 1'b1;
            if (pop) sent_q <= sent_q + 1'b1;
         end
      end
   end

   assign dout_v    = dout_v_c;
   assign dout      = dout_v_c ? fifo_rdata : '0;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_usb_event_annunciator.sv
// Randomised bench for usb_event_annunciator: a queue model of the committed byte stream is
// checked by a negedge monitor on every consumed IN byte.
module tb_usb_event_annunciator;
   import usb_event_annunciator_pkg::*;

   localparam int NCH    = 4;
   localparam int DEPTH  = 32;
   localparam int MAXPKT = 8;
   localparam int EP     = 1;
   localparam int CHW    = $clog2(NCH);
   localparam int CMOD   = 1 << (8 - CHW);
   localparam int LW     = $clog2(DEPTH) + 1;

   logic           clk48 = 1'b0;
   logic           rst;
   logic [NCH-1:0] inc;
   logic           usb_rst;
   logic           transaction_active;
   logic [3:0]     endpoint;
   logic           direction_in;
   logic           setup;
   logic           data_strobe;
   logic           success;
   logic [7:0]     din;
   logic           din_v;
   logic [7:0]     dout;
   logic           dout_v;
   logic [NCH-1:0] lost;
   logic [LW-1:0]  level;
   ann_state_t     fsm_state;

   usb_event_annunciator #(
      .NCH(NCH), .DEPTH(DEPTH), .MAXPKT(MAXPKT), .EP(EP), .BOTH_EDGE(1)
   ) dut (
      .clk48              (clk48),
      .rst                (rst),
      .inc                (inc),
      .usb_rst            (usb_rst),
      .transaction_active (transaction_active),
      .endpoint           (endpoint),
      .direction_in       (direction_in),
      .setup              (setup),
      .data_strobe        (data_strobe),
      .success            (success),
      .din                (din),
      .din_v              (din_v),
      .dout               (dout),
      .dout_v             (dout_v),
      .lost               (lost),
      .level              (level),
      .fsm_state          (fsm_state)
   );

   always #10 clk48 = ~clk48;

   int             tests = 0;
   int             fails = 0;
   logic [7:0]     exp_q[$];
   int             cnt_m[NCH];
   logic [NCH-1:0] mask_m;
   logic [NCH-1:0] lost_m;
   bit             mon_en = 1'b0;
   int             mon_idx = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rec(input int ch);
      return 8'((ch << (8 - CHW)) | cnt_m[ch]);
   endfunction

   function automatic int held_in_fifo();
      return (exp_q.size() < DEPTH) ? exp_q.size() : DEPTH;
   endfunction

   always @(negedge clk48) begin
      if (mon_en && data_strobe && dout_v) begin
         check("in_byte_in_range", 32'(mon_idx < exp_q.size()), 32'd1);
         if (mon_idx < exp_q.size()) check("in_byte", dout, exp_q[mon_idx]);
         mon_idx++;
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_level"}, level, held_in_fifo());
      check({tag, "_lost"}, lost, lost_m);
      check({tag, "_state"}, fsm_state, ST_IDLE);
      check({tag, "_dout_v"}, dout_v, 0);
   endtask

   // Each enabled toggle yields one record; a record still waiting beyond a full FIFO absorbs it.
   task automatic fire(input logic [NCH-1:0] chs);
      @(posedge clk48); #1;
      inc = inc ^ chs;
      for (int i = 0; i < NCH; i++) begin
         if (chs[i] && mask_m[i]) begin
            int slot;
            slot = -1;
            cnt_m[i] = (cnt_m[i] + 1) % CMOD;
            for (int k = DEPTH; k < exp_q.size(); k++)
               if (int'(exp_q[k] >> (8 - CHW)) == i) slot = k;
            if (slot >= 0) begin
               exp_q[slot] = rec(i);
               lost_m[i] = 1'b1;
            end else begin
               exp_q.push_back(rec(i));
            end
         end
      end
      repeat (NCH + 5) @(posedge clk48);
      #1;
   endtask

   task automatic in_txn(input logic [3:0] ep, input bit stp, input bit ok);
      int n;
      int exp_len;
      bit served;
      served  = (ep == 4'(EP)) && !stp;
      exp_len = served ? ((exp_q.size() < MAXPKT) ? exp_q.size() : MAXPKT) : 0;
      @(posedge clk48); #1;
      endpoint = ep; setup = stp; direction_in = 1'b1; transaction_active = 1'b1;
      mon_idx = 0; mon_en = 1'b1;
      @(posedge clk48); #1;
      n = 0;
      while (dout_v && n < MAXPKT + 2) begin
         data_strobe = 1'b1;
         @(posedge clk48); #1;
         data_strobe = 1'b0;
         n++;
         repeat ($urandom_range(0, 1)) begin @(posedge clk48); #1; end
      end
      data_strobe = 1'b1;
      @(posedge clk48); #1;
      data_strobe = 1'b0;
      check("in_len", mon_idx, exp_len);
      if (ok) begin
         success = 1'b1;
         @(posedge clk48); #1;
         success = 1'b0;
      end
      @(posedge clk48); #1;
      transaction_active = 1'b0; mon_en = 1'b0; setup = 1'b0;
      @(posedge clk48); #1;
      if (served && ok) repeat (exp_len) void'(exp_q.pop_front());
      repeat (2) @(posedge clk48);
      #1;
      check_idle("in");
   endtask

   task automatic out_txn(input logic [3:0] ep, input logic [7:0] d, input bit ok);
      @(posedge clk48); #1;
      endpoint = ep; setup = 1'b0; direction_in = 1'b0; transaction_active = 1'b1;
      @(posedge clk48); #1;
      din = d; din_v = 1'b1; data_strobe = 1'b1;
      @(posedge clk48); #1;
      din_v = 1'b0; data_strobe = 1'b0;
      if (ok) begin
         success = 1'b1;
         @(posedge clk48); #1;
         success = 1'b0;
      end
      @(posedge clk48); #1;
      transaction_active = 1'b0;
      @(posedge clk48); #1;
      if (ok && ep == 4'(EP)) mask_m = d[NCH-1:0];
      check_idle("out");
   endtask

   initial begin
      logic [3:0] ep_r;
      rst = 1'b1; usb_rst = 1'b0; inc = '0; transaction_active = 1'b0; endpoint = '0;
      direction_in = 1'b0; setup = 1'b0; data_strobe = 1'b0; success = 1'b0;
      din = '0; din_v = 1'b0;
      mask_m = '1; lost_m = '0;
      for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
      repeat (3) @(posedge clk48);
      #1 rst = 1'b0;
      @(posedge clk48); #1;
      check("rst_dout", dout, 0);
      check("rst_dout_v", dout_v, 0);
      check("rst_lost", lost, 0);
      check("rst_level", level, 0);
      check("rst_state", fsm_state, ST_IDLE);

      // single event, ACKed IN
      fire(4'b0001);
      check_idle("t1_queued");
      in_txn(4'(EP), 1'b0, 1'b1);

      // replay after a failed IN
      repeat (3) fire(4'b0100);
      check_idle("t2_queued");
      in_txn(4'(EP), 1'b0, 1'b0);
      in_txn(4'(EP), 1'b0, 1'b1);

      // same-cycle edges come out in channel order
      fire(4'b1111);
      in_txn(4'(EP), 1'b0, 1'b1);

      // packet size limit
      for (int j = 0; j < 12; j++) fire(NCH'(1 << (j % NCH)));
      check_idle("t5_queued");
      in_txn(4'(EP), 1'b0, 1'b1);
      in_txn(4'(EP), 1'b0, 1'b1);

      // mask writes
      out_txn(4'(EP), 8'h02, 1'b1);
      fire(4'b1111);
      check_idle("t6_masked");
      in_txn(4'(EP), 1'b0, 1'b1);
      out_txn(4'(EP), 8'h0F, 1'b1);
      out_txn(4'(EP), 8'h00, 1'b0);
      out_txn(4'd2, 8'h00, 1'b1);
      fire(4'b1111);
      in_txn(4'd2, 1'b0, 1'b1);
      in_txn(4'(EP), 1'b1, 1'b1);
      in_txn(4'(EP), 1'b0, 1'b1);

      // overflow: a second ch1 event while the first waits behind a full FIFO
      for (int j = 0; j < DEPTH; j++) fire(4'b0001);
      check_idle("t4_full");
      fire(4'b0010);
      fire(4'b0010);
      check_idle("t4_lost");
      for (int j = 0; j < 6; j++) if (exp_q.size() > 0) in_txn(4'(EP), 1'b0, 1'b1);

      // randomised mix
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: begin
               if (exp_q.size() <= DEPTH - NCH) begin
                  fire(NCH'($urandom_range(1, (1 << NCH) - 1)));
                  check_idle("rnd_fire");
               end
            end
            3: in_txn(4'(EP), 1'b0, 1'($urandom_range(0, 1)));
            4: out_txn(4'($urandom_range(1, 2)), 8'($urandom), 1'($urandom_range(0, 1)));
            default: begin
               ep_r = 4'($urandom_range(1, 15));
               in_txn(ep_r, (ep_r == 4'(EP)) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1);
            end
         endcase
      end

      // bus reset in the middle of an ACKed IN: nothing is committed, everything restarts
      out_txn(4'(EP), 8'h0F, 1'b1);
      fire(4'b0011);
      fire(4'b0100);
      @(posedge clk48); #1;
      endpoint = 4'(EP); setup = 1'b0; direction_in = 1'b1; transaction_active = 1'b1;
      @(posedge clk48); #1;
      data_strobe = 1'b1;
      @(posedge clk48); #1;
      data_strobe = 1'b0; success = 1'b1;
      @(posedge clk48); #1;
      success = 1'b0; usb_rst = 1'b1; transaction_active = 1'b0;
      @(posedge clk48); #1;
      usb_rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
      mask_m = '1;
      lost_m = '0;
      @(posedge clk48); #1;
      check_idle("usb_rst");
      fire(4'b1111);
      check_idle("usb_rst_refill");
      in_txn(4'(EP), 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #3000000;
      fails++;
      $display("FAIL watchdog: time limit reached with %0d tests run, expected a finish before it", tests);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule
